ap_hs_call_arbiter: RTL and testbench
=====================================

Name: ap_hs_call_arbiter

Overview:
- Shares one ap_ctrl_hs callee instance among NUM_REQ requesters. The target is an HLS sub-function such as the straight-line projector, which is currently instantiated separately inside solveNextColumn and getParallelograms.
- Arbitrates requests round-robin, latches the winner's arguments, and drives the callee's ap_start/ap_ready/ap_done handshake.
- Returns ap_return to the winner, tagged with its requester index.
- Sits in the MPSQ top between the column/patch solvers and the single shared callee.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ARG_W, 128, width of the packed callee argument bus.
- RES_W, 32, width of callee ap_return.
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden).

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester call request; held until the matching req_ready bit is seen.
- req_args  in  NUM_REQ*ARG_W  per-requester arguments; slice i = [i*ARG_W +: ARG_W].
- req_ready  out  NUM_REQ  one-hot grant pulse; request i is consumed in the cycle that req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  one-cycle result pulse; no backpressure.
- rsp_id  out  IDX_W  requester index for rsp_data.
- rsp_data  out  RES_W  registered callee return value.
- callee_ap_start  out  1  callee start.
- callee_args  out  ARG_W  latched arguments; stable from START until the end of WAIT_DONE.
- callee_ap_ready  in  1  callee has accepted its inputs.
- callee_ap_done  in  1  callee result is valid.
- callee_ap_return  in  RES_W  callee result; sampled when callee_ap_done is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, callee_ap_start=0, callee_args=0, busy=0. Reset mid-call aborts with no rsp_valid. The callee is reset by the same reset.
- FSM states: IDLE, START, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid is high, the round-robin winner is the first set bit at or after rr_ptr, wrapping.
  - req_ready[winner]=1 combinationally, in the same cycle.
  - Latch req_args[winner] into callee_args and winner into gnt_id.
  - Set rr_ptr = winner+1 mod NUM_REQ, then go to START.
  - With no request, stay in IDLE.
- START:
  - callee_ap_start=1 (registered).
  - callee_ap_ready&&callee_ap_done: latch ap_return, go to RESP.
  - callee_ap_ready only: go to WAIT_DONE.
  - Neither: stay in START with ap_start held high.
- WAIT_DONE:
  - callee_ap_start=0.
  - On callee_ap_done: latch ap_return into rsp_data, go to RESP.
- RESP:
  - rsp_valid=1, rsp_id=gnt_id for exactly one cycle, then go to IDLE.
  - rsp_data holds its value until the next latch.
- Latency: req_valid in cycle 0 (IDLE) → ap_start in cycle 1 → ready&done in cycle 1 → rsp_valid in cycle 2. Minimum of 3 cycles per call; issue rate is at most one call per 3 cycles plus callee latency.
- req_valid seen outside IDLE is ignored (req_ready=0 there). Dropping req_valid before req_ready is legal and withdraws the request.
- A callee_ap_done seen in IDLE is ignored.
- A spurious callee_ap_ready in WAIT_DONE is ignored.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait with no starvation (bounded by NUM_REQ calls).

Optional Feature:
- Macro: AP_HS_CALL_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_calls (NUM_REQ*16): per-requester completed-call counters, +1 on rsp_valid for rsp_id.
  - Adds output perf_busy (32): cycles with busy=1.
  - All counters saturate at their maximum and are cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mpsq_arb_pkg holds:
  - the FSM enum arb_state_t {IDLE, START, WAIT_DONE, RESP};
  - the perf counter width constants PERF_CALL_W=16 and PERF_BUSY_W=32.
- Sub-module rr_arbiter holds the combinational round-robin pick from req_valid and rr_ptr to a one-hot grant and index.
- Top module holds the FSM, the argument/result registers and the optional counters.

Test Plan:
- Ready and done together: req_valid[2] with args=0xA5, callee ready&done in cycle 1 with return=0x1234 → req_ready[2] in cycle 0, rsp_valid in cycle 2, rsp_id=2, rsp_data=0x1234.
- Delayed done: ready in cycle 1, done in cycle 6 → ap_start high only in cycle 1, callee_args stable through cycle 6, rsp_valid in cycle 7.
- Delayed ready: ready arrives 3 cycles after start → ap_start held high in START for 4 cycles, then deasserts.
- Round-robin: all 4 requesters held high continuously → grant order 0,1,2,3,0 with rsp_id matching each grant.
- Reset mid-call: assert reset while in WAIT_DONE → busy=0 and all outputs at reset values asynchronously; no rsp_valid; next request after reset is granted to requester 0 first.
- Perf counters (with AP_HS_CALL_ARBITER_PERF_EN defined): 5 calls from requester 1, each with 4-cycle callee latency → perf_calls slice 1 = 5, perf_busy = the sum of busy cycles.

Source files
------------

// File: rtl/mpsq_arb_pkg.sv
// Shared types and constants for the ap_ctrl_hs call arbiter (ap_hs_call_arbiter).
package mpsq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        RESP
    } arb_state_t;

    localparam int unsigned PERF_CALL_W = 16;
    localparam int unsigned PERF_BUSY_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request bit at or after ptr, wrapping.
module rr_arbiter
    import mpsq_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/ap_hs_call_arbiter.sv
// Shares one ap_ctrl_hs callee among NUM_REQ requesters with round-robin arbitration.
// Optional perf counters are enabled by defining AP_HS_CALL_ARBITER_PERF_EN.
module ap_hs_call_arbiter
    import mpsq_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ARG_W   = 128,
    parameter  int unsigned RES_W   = 32,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ARG_W-1:0] req_args,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [IDX_W-1:0]         rsp_id,
    output logic [RES_W-1:0]         rsp_data,
    output logic                     callee_ap_start,
    output logic [ARG_W-1:0]         callee_args,
    input  logic                     callee_ap_ready,
    input  logic                     callee_ap_done,
    input  logic [RES_W-1:0]         callee_ap_return,
    output logic                     busy
`ifdef AP_HS_CALL_ARBITER_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CALL_W-1:0] perf_calls,
    output logic [PERF_BUSY_W-1:0]         perf_busy
`endif
);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_id;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             any_req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .any    (any_req)
    );

    // The grant is only offered while idle, so requests seen mid-call simply wait.
    assign req_ready = (state == IDLE) ? gnt : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            gnt_id          <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_data        <= '0;
            callee_ap_start <= 1'b0;
            callee_args     <= '0;
            busy            <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        callee_args     <= req_args[32'(gnt_idx)*ARG_W +: ARG_W];
                        gnt_id          <= gnt_idx;
                        rr_ptr          <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        callee_ap_start <= 1'b1;
                        busy            <= 1'b1;
                        state           <= START;
                    end
                end
                START: begin
                    if (callee_ap_ready) begin
                        callee_ap_start <= 1'b0;
                        if (callee_ap_done) begin
                            rsp_data  <= callee_ap_return;
                            rsp_valid <= 1'b1;
                            rsp_id    <= gnt_id;
                            state     <= RESP;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (callee_ap_done) begin
                        rsp_data  <= callee_ap_return;
                        rsp_valid <= 1'b1;
                        rsp_id    <= gnt_id;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AP_HS_CALL_ARBITER_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_calls <= '0;
            perf_busy  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid && rsp_id == IDX_W'(i) &&
                    perf_calls[i*PERF_CALL_W +: PERF_CALL_W] != '1) begin
                    perf_calls[i*PERF_CALL_W +: PERF_CALL_W] <=
                        perf_calls[i*PERF_CALL_W +: PERF_CALL_W] + 1'b1;
                end
            end
            if (busy && perf_busy != '1) begin
                perf_busy <= perf_busy + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ap_hs_call_arbiter.sv
// Randomized scoreboard bench for ap_hs_call_arbiter against a cycle-count reference model.
module tb_ap_hs_call_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 128;
    localparam int unsigned RW = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*AW-1:0] req_args = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [RW-1:0]   rsp_data;
    logic            callee_ap_start;
    logic [AW-1:0]   callee_args;
    logic            callee_ap_ready = 1'b0;
    logic            callee_ap_done = 1'b0;
    logic [RW-1:0]   callee_ap_return = '0;
    logic            busy;
`ifdef AP_HS_CALL_ARBITER_PERF_EN
    logic [NR*16-1:0] perf_calls;
    logic [31:0]      perf_busy;
`endif

    ap_hs_call_arbiter #(
        .NUM_REQ(NR),
        .ARG_W  (AW),
        .RES_W  (RW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_args        (req_args),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .callee_ap_start (callee_ap_start),
        .callee_args     (callee_args),
        .callee_ap_ready (callee_ap_ready),
        .callee_ap_done  (callee_ap_done),
        .callee_ap_return(callee_ap_return),
        .busy            (busy)
`ifdef AP_HS_CALL_ARBITER_PERF_EN
        ,
        .perf_calls      (perf_calls),
        .perf_busy       (perf_busy)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a call granted in cycle g with ready delay R and extra done delay D
    // starts in g+1, sees ready in g+1+R, done in g+1+R+D, responds in g+2+R+D.
    bit           m_busy = 1'b0;
    int           g = 0, mR = 0, mD = 0;
    int           m_ptr = 0;
    logic [3:0]   pend = '0;
    logic [127:0] pargs [4];
    logic [127:0] gargs = '0;
    logic [31:0]  last_data = '0;
    int           grants[$];
    exp_t         sbq[$];
    bit           rnd_mode = 1'b0;
    bit           hold_all = 1'b0;
    bit           forced = 1'b1;
    int           fR = 0, fD = 0;
    int           busy_cnt = 0;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // What the modelled callee computes from its argument bus.
    function automatic logic [31:0] fret(input logic [127:0] a);
        return (a[31:0] ^ a[127:96]) + a[95:64];
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (((v >> j) & 4'd1) != 4'd0) return j;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        int         w;
        logic [3:0] eg;
        if (rnd_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[i]  = 1'b1;
                        pargs[i] = rand128();
                    end
                end else if ($urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        req_valid = pend;
        for (int i = 0; i < 4; i++) req_args[i*128 +: 128] = pargs[i];
        callee_ap_ready  = 1'b0;
        callee_ap_done   = 1'b0;
        callee_ap_return = $urandom;
        if (m_busy) begin
            if (cyc == g + 1 + mR) callee_ap_ready = 1'b1;
            else if (rnd_mode && cyc > g + 1 + mR && $urandom_range(3) == 0) callee_ap_ready = 1'b1;
            if (cyc == g + 1 + mR + mD) begin
                callee_ap_done   = 1'b1;
                callee_ap_return = fret(callee_args);
            end
        end else if (rnd_mode && $urandom_range(3) == 0) begin
            callee_ap_done = 1'b1;
        end
        #1;
        w  = m_busy ? -1 : rr_pick(pend, m_ptr);
        eg = (w >= 0) ? 4'(1 << w) : 4'b0000;
        check("req_ready", req_ready, eg);
        check("busy", busy, m_busy);
        check("ap_start", callee_ap_start, m_busy && cyc <= g + 1 + mR);
        check("rsp_valid_timing", rsp_valid, m_busy && cyc == g + 2 + mR + mD);
        check("rsp_data_hold", rsp_data, last_data);
        if (m_busy && cyc <= g + 1 + mR + mD) check("callee_args", callee_args, gargs);
        if (m_busy) busy_cnt++;
        if (w >= 0) begin
            sbq.push_back('{w, fret(pargs[w])});
            gargs  = pargs[w];
            m_ptr  = (w + 1) % 4;
            m_busy = 1'b1;
            g      = cyc;
            mR     = forced ? fR : int'($urandom_range(3));
            mD     = forced ? fD : int'($urandom_range(4));
            grants.push_back(w);
            if (hold_all) pargs[w] = rand128();
            else pend[w] = 1'b0;
        end else if (m_busy) begin
            if (cyc == g + 1 + mR + mD) last_data = fret(gargs);
            if (cyc == g + 2 + mR + mD) m_busy = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int maxc, input string name);
        int n = 0;
        while ((m_busy || pend != 4'b0000) && n < maxc) begin
            step();
            n++;
        end
        check({name, "_idle"}, {m_busy, pend}, 5'b0);
        check({name, "_scoreboard_drained"}, sbq.size(), 0);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        req_valid       = '0;
        callee_ap_ready = 1'b0;
        callee_ap_done  = 1'b0;
        pend            = '0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 4'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 2'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_ap_start", callee_ap_start, 1'b0);
        check("rst_callee_args", callee_args, 128'd0);
`ifdef AP_HS_CALL_ARBITER_PERF_EN
        check("rst_perf_calls", perf_calls, 64'd0);
        check("rst_perf_busy", perf_busy, 32'd0);
`endif
        sbq.delete();
        grants.delete();
        m_busy    = 1'b0;
        m_ptr     = 0;
        last_data = '0;
        busy_cnt  = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    always @(negedge clock) begin
        if (!reset && rsp_valid) begin
            exp_t e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
            end else begin
                e = sbq.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_payload", rsp_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) pargs[i] = '0;
        #2;
        do_reset();

        // Ready and done together in the first START cycle.
        pend[2] = 1'b1; pargs[2] = 128'hA5; fR = 0; fD = 0;
        run_until_idle(50, "ready_done");
        check("ready_done_grant", grants[0], 2);

        // Delayed done: done five cycles after ready.
        pend[0] = 1'b1; pargs[0] = rand128(); fR = 0; fD = 5;
        run_until_idle(50, "delayed_done");

        // Delayed ready: ap_start held for four cycles.
        pend[3] = 1'b1; pargs[3] = rand128(); fR = 3; fD = 1;
        run_until_idle(50, "delayed_ready");

        // Round-robin with all requesters held continuously.
        do_reset();
        for (int i = 0; i < 4; i++) pargs[i] = rand128();
        pend = 4'hF; hold_all = 1'b1; fR = 0; fD = 0;
        for (int n = 0; n < 100 && grants.size() < 5; n++) step();
        hold_all = 1'b0;
        pend = '0;
        run_until_idle(50, "rr");
        for (int k = 0; k < 5; k++) begin
            if (grants.size() > k) check("rr_order", grants[k], exp_order[k]);
            else check("rr_order_count", grants.size(), 5);
        end

        // Reset while waiting for done aborts the call.
        pend[2] = 1'b1; pargs[2] = rand128(); fR = 0; fD = 10;
        repeat (5) step();
        check("pre_reset_busy", busy, 1'b1);
        do_reset();
        pend = 4'b1001; pargs[0] = rand128(); pargs[3] = rand128(); fR = 1; fD = 2;
        step();
        check("post_reset_first_grant", grants.size() > 0 ? grants[0] : -1, 0);
        run_until_idle(50, "post_reset");

        // Randomized traffic, spurious done while idle and spurious ready while waiting.
        rnd_mode = 1'b1; forced = 1'b0;
        repeat (400) step();
        rnd_mode = 1'b0; forced = 1'b1;
        pend = '0;
        run_until_idle(50, "random");

`ifdef AP_HS_CALL_ARBITER_PERF_EN
        do_reset();
        fR = 0; fD = 3;
        for (int n = 0; n < 5; n++) begin
            pend[1] = 1'b1; pargs[1] = rand128();
            run_until_idle(50, "perf");
        end
        check("perf_calls_1", perf_calls[16 +: 16], 16'd5);
        check("perf_calls_0", perf_calls[0 +: 16], 16'd0);
        check("perf_busy", perf_busy, busy_cnt);
`endif

        check("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
